// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Fetch addresses are always word aligned; low two bits are cleared.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding instruction-memory read, registered
// instruction/pc to decode, redirect handling with stale-response squash.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  REQ   | request at fpc presented, waiting for memory to accept it
//  WAIT  | request outstanding, waiting for the response (drop = discard it)
//  HOLD  | fetched instruction held for decode until consumed or redirected
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        rsp_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_err,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ifu_state_t  state, state_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic        drop, drop_nxt;
    logic        inst_valid_nxt;
    logic [31:0] inst_nxt, pc_nxt;
    logic        inst_err_nxt;
    logic [31:0] redirect_target;

    assign redirect_target = align_pc(redirect_pc);

    assign req_valid = (state == REQ);
    assign req_addr  = fpc;
    assign rsp_ready = (state == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= REQ;
            fpc        <= align_pc(RESET_PC);
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            pc         <= '0;
            inst_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            fpc        <= fpc_nxt;
            drop       <= drop_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            pc         <= pc_nxt;
            inst_err   <= inst_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fpc_nxt        = fpc;
        drop_nxt       = drop;
        inst_valid_nxt = inst_valid;
        inst_nxt       = inst;
        pc_nxt         = pc;
        inst_err_nxt   = inst_err;

        case (state)
            REQ: begin
                if (redirect_valid) begin
                    fpc_nxt = redirect_target;
                end
                if (req_ready) begin
                    // A redirect on the accept cycle leaves the old-address
                    // request in flight; its response must be thrown away.
                    drop_nxt  = redirect_valid;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fpc_nxt = redirect_target;
                    if (rsp_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        inst_nxt       = rsp_err ? 32'h0 : rsp_data;
                        inst_err_nxt   = rsp_err;
                        pc_nxt         = fpc;
                        inst_valid_nxt = 1'b1;
                        fpc_nxt        = fpc + 32'd4;
                        state_nxt      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    inst_valid_nxt = 1'b0;
                    fpc_nxt        = redirect_target;
                    state_nxt      = REQ;
                end else if (inst_ready) begin
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a scoreboard queue holds the instructions the
// bench expects decode to see, filled when a response is driven.
module tb_ifu;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_err;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_ready      (rsp_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc),
        .inst_err       (inst_err),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Wait (bounded) for a request and check its address and how long it took.
    task automatic wait_req(input logic [31:0] addr, input int max_wait);
        int n = 0;
        while (!req_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!req_valid || n > max_wait) begin
            errors++;
            $display("FAIL req_timing: req_valid=%b after %0d cycles, required within %0d", req_valid, n, max_wait);
        end
        checks++;
        if (req_addr !== addr) begin
            errors++;
            $display("FAIL req_addr: got %h, expected %h", req_addr, addr);
        end
    endtask

    // Accept a request at addr, answer after lat cycles, land in HOLD.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input int lat, input int max_wait);
        wait_req(addr, max_wait);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        for (int i = 1; i < lat; i++) step();
        checks++;
        if (rsp_ready !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: rsp_ready=%b inst_valid=%b, expected 1 0", rsp_ready, inst_valid);
        end
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        sb.push_back('{pc: addr, inst: (err ? 32'h0 : data), err: err});
        step();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL inst_arrive: inst_valid=%b req_valid=%b, expected 1 0", inst_valid, req_valid);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: instruction presented with empty scoreboard, pc=%h", tag, pc);
        end else begin
            e = sb.pop_front();
            if (inst !== e.inst || pc !== e.pc || inst_err !== e.err || inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_inst: got v=%b inst=%h pc=%h err=%b, expected v=1 inst=%h pc=%h err=%b",
                         tag, inst_valid, inst, pc, inst_err, e.inst, e.pc, e.err);
            end
        end
    endtask

    // Hold decode off for stall cycles, then consume the instruction.
    task automatic consume(input int stall);
        logic [31:0] i0, p0;
        i0 = inst;
        p0 = pc;
        for (int i = 0; i < stall; i++) begin
            step();
            checks++;
            if (inst !== i0 || pc !== p0 || inst_valid !== 1'b1 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d inst=%h pc=%h v=%b req_valid=%b", i, inst, pc, inst_valid, req_valid);
            end
        end
        pop_compare("consume");
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_clear: inst_valid=%b, expected 0", inst_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        step();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || rsp_ready !== 1'b0 ||
            inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0 || inst_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: req_valid=%b req_addr=%h rsp_ready=%b v=%b inst=%h pc=%h err=%b",
                     req_valid, req_addr, rsp_ready, inst_valid, inst, pc, inst_err);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        issue(32'h8000_0000, 32'h0000_0013, 1'b0, 1, 0);
        consume(0);
        issue(32'h8000_0004, 32'h0010_0093, 1'b0, 1, 0);
        consume(0);
        issue(32'h8000_0008, 32'h0020_8113, 1'b0, 1, 0);
        consume(0);
    endtask

    task automatic test_stall();
        issue(32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 3, 0);
        consume(5);
    endtask

    task automatic test_fault();
        issue(32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 1, 0);
        consume(0);
    endtask

    task automatic test_redirect_wait();
        wait_req(32'h8000_0014, 0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (rsp_ready !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_hold: rsp_ready=%b req_valid=%b, expected 1 0", rsp_ready, req_valid);
        end
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0_0014;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_drop: inst_valid=%b, expected 0", inst_valid);
        end
        issue(32'h8000_0100, 32'h1234_5678, 1'b0, 2, 0);
        consume(0);
    endtask

    task automatic test_redirect_rsp_same();
        wait_req(32'h8000_0104, 0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0_0104;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_0200) begin
            errors++;
            $display("FAIL redir_same: v=%b req_valid=%b req_addr=%h, expected 0 1 80000200", inst_valid, req_valid, req_addr);
        end
        issue(32'h8000_0200, 32'hCAFE_0200, 1'b0, 1, 0);
        consume(0);
    endtask

    task automatic test_redirect_hold();
        issue(32'h8000_0204, 32'h0000_006F, 1'b0, 1, 0);
        pop_compare("redir_hold");
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL redir_hold_target: v=%b req_valid=%b req_addr=%h, expected 0 1 fffffffc", inst_valid, req_valid, req_addr);
        end
        issue(32'hFFFF_FFFC, 32'h0A0B_0C0D, 1'b0, 1, 0);
        consume(0);
    endtask

    task automatic test_req_redirect();
        wait_req(32'h0000_0000, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0301;
        rsp_valid      = 1'b1;
        rsp_data       = 32'hBAD0_0000;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0000_0300 || inst_valid !== 1'b0 || rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL req_redirect: req_valid=%b req_addr=%h v=%b rsp_ready=%b, expected 1 00000300 0 0",
                     req_valid, req_addr, inst_valid, rsp_ready);
        end
        redirect_pc = 32'h0000_0400;
        req_ready   = 1'b1;
        step();
        req_ready = 1'b0;
        redirect_valid = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0_0300;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL accept_redirect: v=%b req_valid=%b req_addr=%h, expected 0 1 00000400", inst_valid, req_valid, req_addr);
        end
        issue(32'h0000_0400, 32'h5555_AAAA, 1'b0, 1, 0);
        consume(2);
    endtask

    task automatic test_squash();
        issue(32'h0000_0404, 32'h7777_0404, 1'b0, 1, 0);
        pop_compare("squash");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h0000_0800) begin
            errors++;
            $display("FAIL squash: v=%b req_valid=%b req_addr=%h, expected 0 1 00000800", inst_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        wait_req(32'h0000_0800, 0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || rsp_ready !== 1'b0 || pc !== 32'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: req_valid=%b req_addr=%h rsp_ready=%b pc=%h v=%b",
                     req_valid, req_addr, rsp_ready, pc, inst_valid);
        end
        step();
        rst = 1'b1;
        issue(32'h8000_0000, 32'h0000_0013, 1'b0, 1, 0);
        consume(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_fault();
        test_redirect_wait();
        test_redirect_rsp_same();
        test_redirect_hold();
        test_req_redirect();
        test_squash();
        test_reset_mid_wait();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected instructions never delivered", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
